// File: rtl/pulse_event_capture.sv
// pulse_event_capture: edge-detects filtered pulse channels, timestamps each edge and queues events on a valid/ready stream.
// Define PULSE_EVENT_FALL_EN to capture falling edges too; by default only rising edges are captured.
module pulse_event_capture #(
    parameter int NUM_CH     = 32,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_WIDTH  = 16,
    localparam int CW = $clog2(NUM_CH),
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic [NUM_CH-1:0]   pulse_in,
    input  logic [NUM_CH-1:0]   chan_en,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CW-1:0]       evt_chan,
    output logic [TS_WIDTH-1:0] evt_time,
    output logic                evt_rise,
    output logic [AW:0]         fifo_level,
    output logic [OVF_WIDTH-1:0] lost_cnt
);
    logic [NUM_CH-1:0]   pulse_d1_q, pend_q, pend_d, cap, win, busy, drop;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] stamp_q [NUM_CH];
    logic [CW-1:0]       mem_chan_q [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] mem_time_q [FIFO_DEPTH];
    logic [AW:0]         wr_q, rd_q;
    logic [OVF_WIDTH-1:0] lost_q;
    logic [CW-1:0]       sel;
    logic                full, push, pop;

`ifdef PULSE_EVENT_FALL_EN
    logic [NUM_CH-1:0]     etype_q, fall;
    logic [FIFO_DEPTH-1:0] mem_rise_q;
    assign fall     = ~pulse_in & pulse_d1_q & chan_en;
    assign cap      = (pulse_in & ~pulse_d1_q & chan_en) | fall;
    assign evt_rise = mem_rise_q[rd_q[AW-1:0]];
`else
    assign cap      = pulse_in & ~pulse_d1_q & chan_en;
    assign evt_rise = evt_valid;
`endif

    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pend_q[i]) sel = CW'(i);
    end

    assign fifo_level = wr_q - rd_q;
    assign evt_valid  = wr_q != rd_q;
    assign full       = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign pop        = evt_valid & evt_ready;
    assign push       = (|pend_q) & (~full | pop);
    assign win        = push ? (NUM_CH'(1) << sel) : '0;
    // A channel being written this clock is free to take a new edge (clear-and-set).
    assign busy       = pend_q & ~win;
    assign drop       = cap & busy;
    assign pend_d     = cap | busy;
    assign evt_chan   = mem_chan_q[rd_q[AW-1:0]];
    assign evt_time   = mem_time_q[rd_q[AW-1:0]];
    assign lost_cnt   = lost_q;

    // Keeps sampling through clear so a level held across clear raises no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse_d1_q <= '0;
        else        pulse_d1_q <= pulse_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            pend_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            lost_q <= '0;
            for (int i = 0; i < NUM_CH; i++) stamp_q[i] <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_chan_q[j] <= '0;
                mem_time_q[j] <= '0;
            end
`ifdef PULSE_EVENT_FALL_EN
            etype_q    <= '0;
            mem_rise_q <= '0;
`endif
        end else begin
            ts_q   <= clear ? '0 : ts_q + 1'b1;
            pend_q <= clear ? '0 : pend_d;
            wr_q   <= clear ? '0 : wr_q + (AW+1)'(push);
            rd_q   <= clear ? '0 : rd_q + (AW+1)'(pop);
            lost_q <= clear ? '0 : lost_q + OVF_WIDTH'(|drop && !(&lost_q));
            for (int i = 0; i < NUM_CH; i++)
                if (clear || (cap[i] && !busy[i])) begin
                    stamp_q[i] <= clear ? '0 : ts_q;
`ifdef PULSE_EVENT_FALL_EN
                    etype_q[i] <= clear ? 1'b0 : ~fall[i];
`endif
                end
            for (int j = 0; j < FIFO_DEPTH; j++)
                if (clear || (push && wr_q[AW-1:0] == AW'(j))) begin
                    mem_chan_q[j] <= clear ? '0 : sel;
                    mem_time_q[j] <= clear ? '0 : stamp_q[sel];
`ifdef PULSE_EVENT_FALL_EN
                    mem_rise_q[j] <= clear ? 1'b0 : etype_q[sel];
`endif
                end
        end
    end
endmodule

// File: tb/tb_pulse_event_capture.sv
// tb_pulse_event_capture: directed stimulus with an expected-event queue checked by an independent monitor.
module tb_pulse_event_capture;
    logic        clk = 0, rst_n = 0, clear = 0, evt_ready = 0;
    logic [31:0] pulse_in = '0, chan_en = '1;
    logic        evt_valid, evt_rise;
    logic [4:0]  evt_chan, fifo_level;
    logic [15:0] evt_time, lost_cnt, tsm, t;
    int          checks = 0, errors = 0;

    typedef struct packed {logic [4:0] ch; logic [15:0] tm; logic r;} ev_t;
    ev_t expq[$];

    pulse_event_capture dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pulse_in(pulse_in), .chan_en(chan_en),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan), .evt_time(evt_time),
        .evt_rise(evt_rise), .fifo_level(fifo_level), .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    // Free-running timestamp reference: zero under reset or clear, +1 otherwise.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tsm <= '0;
        else        tsm <= clear ? 16'h0 : tsm + 16'h1;

    always @(negedge clk)
        if (rst_n && evt_valid && evt_ready) begin
            ev_t a, e;
            a = {evt_chan, evt_time, evt_rise};
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got ch=%0d time=%h rise=%0d, required none", evt_chan, evt_time, evt_rise);
            end else begin
                e = expq.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL event: got ch=%0d time=%h rise=%0d, required ch=%0d time=%h rise=%0d",
                             a.ch, a.tm, a.r, e.ch, e.tm, e.r);
                end
            end
        end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", n, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ts(input logic [15:0] v);
        int n = 0;
        while (tsm != v && n < 70000) begin
            step();
            n++;
        end
        chk("wait_ts", 32'(tsm), 32'(v));
    endtask

    task automatic expect_ev(input int ch, input logic [15:0] tm, input logic r);
        expq.push_back({5'(ch), tm, r});
    endtask

    // Lower pulses with the channel disabled so no falling edge is captured in either build.
    task automatic quiet(input logic [31:0] m);
        chan_en  &= ~m;
        pulse_in &= ~m;
        step();
        chan_en  |= m;
    endtask

    initial begin
        step(3);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_lost", 32'(lost_cnt), 0);
        chk("rst_chan", 32'(evt_chan), 0);
        chk("rst_time", 32'(evt_time), 0);
        chk("rst_rise", 32'(evt_rise), 0);
        rst_n = 1;
        evt_ready = 1;

        wait_ts(16'h0010);
        pulse_in[5] = 1;
        expect_ev(5, 16'h0010, 1);
        step();
        chk("lat_sample_valid", 32'(evt_valid), 0);
        step();
        chk("lat_write_valid", 32'(evt_valid), 1);
        chk("lat_write_level", 32'(fifo_level), 1);
        step();
        chk("single_drain_level", 32'(fifo_level), 0);
        quiet(32'h20);

        t = tsm;
        pulse_in |= 32'h8000_0009;
        expect_ev(0, t, 1);
        expect_ev(3, t, 1);
        expect_ev(31, t, 1);
        step(6);
        chk("prio_level", 32'(fifo_level), 0);
        quiet(32'h8000_0009);

        evt_ready = 0;
        t = tsm;
        pulse_in |= 32'hFFFF_0000;
        for (int c = 16; c < 32; c++) expect_ev(c, t, 1);
        step(18);
        chk("fill_level", 32'(fifo_level), 16);
        quiet(32'hFFFF_0000);
        t = tsm;
        pulse_in[7] = 1;
        expect_ev(7, t, 1);
        step();
        pulse_in[7] = 0;
        chan_en[7] = 0;
        step();
        chan_en[7] = 1;
        step();
        pulse_in[7] = 1;
        step();
        chk("coll_lost", 32'(lost_cnt), 1);
        quiet(32'h80);
        chk("coll_level", 32'(fifo_level), 16);
        evt_ready = 1;
        step(20);
        chk("coll_drain_level", 32'(fifo_level), 0);

        evt_ready = 0;
        t = tsm;
        pulse_in |= 32'h000F_FFFF;
        for (int c = 0; c < 20; c++) expect_ev(c, t, 1);
        step(18);
        chk("bp_level", 32'(fifo_level), 16);
        chk("bp_no_drop", 32'(lost_cnt), 1);
        evt_ready = 1;
        step();
        chk("full_push_pop_level", 32'(fifo_level), 16);
        step(25);
        chk("bp_drain_level", 32'(fifo_level), 0);
        quiet(32'h000F_FFFF);

        wait_ts(16'hFFFF);
        pulse_in[1] = 1;
        expect_ev(1, 16'hFFFF, 1);
        step();
        pulse_in[2] = 1;
        expect_ev(2, 16'h0000, 1);
        chan_en[1] = 0;
        pulse_in[1] = 0;
        step();
        chan_en[1] = 1;
        step(4);

        evt_ready = 0;
        pulse_in[4] = 1;
        step(3);
        chk("pre_clear_level", 32'(fifo_level), 1);
        clear = 1;
        step();
        clear = 0;
        chk("clear_level", 32'(fifo_level), 0);
        chk("clear_valid", 32'(evt_valid), 0);
        chk("clear_lost", 32'(lost_cnt), 0);
        evt_ready = 1;
        step(5);
        wait_ts(16'h0008);
        pulse_in[8] = 1;
        expect_ev(8, 16'h0008, 1);
        step(4);

        chan_en[12] = 0;
        pulse_in[12] = 1;
        step(4);
        pulse_in[12] = 0;
        step();
        chan_en[12] = 1;
        chk("disabled_level", 32'(fifo_level), 0);
        quiet(32'h0000_0114);

        t = tsm;
        pulse_in[9] = 1;
        expect_ev(9, t, 1);
        step(4);
        pulse_in[9] = 0;
`ifdef PULSE_EVENT_FALL_EN
        expect_ev(9, 16'(t + 16'd4), 0);
`endif
        step(5);

        evt_ready = 0;
        pulse_in[10] = 1;
        pulse_in[11] = 1;
        step(4);
        chk("pre_reset_level", 32'(fifo_level), 2);
        rst_n = 0;
        #1;
        chk("async_reset_level", 32'(fifo_level), 0);
        chk("async_reset_valid", 32'(evt_valid), 0);
        pulse_in = '0;
        step(2);
        rst_n = 1;
        evt_ready = 1;
        step(3);
        chk("post_reset_lost", 32'(lost_cnt), 0);
        chk("all_events_seen", 32'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
